mm_io_ctrl: RTL and testbench

- Parametrised host-side I/O controller for an ARRAY_SIZE x ARRAY_SIZE systolic matrix-multiply engine.
- Buffers operand rows A and B written by the host, starts the engine, and serves engine operand reads with 1-cycle latency.
- Captures the engine's diagonally skewed result words and de-skews them.
- Streams the result matrix C back one row per beat over a valid/ready handshake, with completeness error detection.

---
 rtl/mm_io_ctrl_if.sv | 66 ++++++
 rtl/mm_io_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mm_io_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// mm_io_ctrl_if
//
// Bundles every non-clock signal of the matrix-multiply I/O controller.
//
// Signal groups:
//   host load    : input_valid, input_ready, load_addr, load_data_a,
//                  load_data_b, load_last
//   engine read  : eng_raddr_a/b in, eng_rdata_a/b out (1-cycle latency)
//   engine write : eng_start out, eng_wen, eng_waddr, eng_wdata, eng_done in
//   result out   : out_valid, out_ready, out_data, out_last
//   status       : busy, err
//
// Modports:
//   master : the host/engine side that drives the controller
//   slave  : the controller itself (mm_io_ctrl)
// ---------------------------------------------------------------------------
interface mm_io_ctrl_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int W          = 16,
  parameter int ADDR_WIDTH = 8
);
  localparam int SW = $clog2(2 * ARRAY_SIZE);

  logic                             input_valid;
  logic                             input_ready;
  logic [ADDR_WIDTH-1:0]            load_addr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] load_data_a;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] load_data_b;
  logic                             load_last;

  logic                             eng_start;
  logic [ADDR_WIDTH-1:0]            eng_raddr_a;
  logic [ADDR_WIDTH-1:0]            eng_raddr_b;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] eng_rdata_a;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] eng_rdata_b;
  logic                             eng_wen;
  logic [SW-1:0]                    eng_waddr;
  logic [ARRAY_SIZE*W-1:0]          eng_wdata;
  logic                             eng_done;

  logic                             out_valid;
  logic                             out_ready;
  logic [ARRAY_SIZE*W-1:0]          out_data;
  logic                             out_last;

  logic                             busy;
  logic                             err;

  modport master (
    output input_valid, load_addr, load_data_a, load_data_b, load_last,
    output eng_raddr_a, eng_raddr_b, eng_wen, eng_waddr, eng_wdata, eng_done,
    output out_ready,
    input  input_ready, eng_start, eng_rdata_a, eng_rdata_b,
    input  out_valid, out_data, out_last, busy, err
  );

  modport slave (
    input  input_valid, load_addr, load_data_a, load_data_b, load_last,
    input  eng_raddr_a, eng_raddr_b, eng_wen, eng_waddr, eng_wdata, eng_done,
    input  out_ready,
    output input_ready, eng_start, eng_rdata_a, eng_rdata_b,
    output out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/mm_io_ctrl.sv
// ---------------------------------------------------------------------------
// mm_io_ctrl
//
// Host-side I/O controller for an ARRAY_SIZE x ARRAY_SIZE systolic
// matrix-multiply engine. The host loads operand rows A/B, the controller
// pulses eng_start, serves engine operand reads with one cycle of latency,
// captures the engine's diagonally skewed result words and streams the
// de-skewed result matrix back one row per valid/ready beat.
//
// Ports:
//   clock : clock
//   reset : synchronous, active-high reset
//   bus   : mm_io_ctrl_if.slave (load, engine, result and status signals)
//
// Skewed word s, lane k (bits [(N-k)*W-1 -: W]) carries C[k][s-k]. Output
// row i element j is therefore word[i+j] lane i.
// ---------------------------------------------------------------------------
module mm_io_ctrl #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int W          = 16,
  parameter int ADDR_WIDTH = 8
) (
  input logic          clock,
  input logic          reset,
  mm_io_ctrl_if.slave  bus
);

  localparam int N     = ARRAY_SIZE;
  localparam int NW    = 2 * N - 1;
  localparam int SW    = $clog2(2 * N);
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = 16;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OW    = N * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    res_q [NW][N];
  logic [W-1:0]    res_d [NW][N];
  logic [OW-1:0]   rdata_a_q, rdata_a_d;
  logic [OW-1:0]   rdata_b_q, rdata_b_d;

  logic [OW-1:0]   mem_a [DEPTH];
  logic [OW-1:0]   mem_b [DEPTH];

  logic            load_fire;
  logic            wr_in_range;
  logic            wr_ok;
  logic [CW-1:0]   count_inc;
  logic [N*W-1:0]  out_data_c;

  assign bus.input_ready = (state_q == IDLE) || (state_q == LOAD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.eng_start   = start_q;
  assign bus.err         = err_q;
  assign bus.out_valid   = (state_q == DRAIN);
  assign bus.out_last    = (state_q == DRAIN) && (row_q == RW'(N - 1));
  assign bus.out_data    = out_data_c;
  assign bus.eng_rdata_a = rdata_a_q;
  assign bus.eng_rdata_b = rdata_b_q;

  assign load_fire   = bus.input_valid && bus.input_ready;
  assign wr_in_range = (bus.eng_waddr < SW'(NW));
  assign wr_ok       = (state_q == RUN) && bus.eng_wen && wr_in_range;
  // Count including a write in this very cycle, so eng_done sees it.
  assign count_inc   = count_q + CW'(wr_ok);

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    err_d   = err_q;
    row_d   = row_q;
    count_d = count_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE, LOAD: begin
        if (load_fire) begin
          if (state_q == IDLE) begin
            err_d = 1'b0;
          end
          if (bus.load_last) begin
            // Clear the result buffer on the way in so RUN starts clean
            // and a write in the first RUN cycle is not lost.
            state_d = RUN;
            start_d = 1'b1;
            count_d = '0;
            for (int s = 0; s < NW; s++) begin
              for (int k = 0; k < N; k++) begin
                res_d[s][k] = '0;
              end
            end
          end else begin
            state_d = LOAD;
          end
        end
      end

      RUN: begin
        if (bus.eng_wen) begin
          if (wr_in_range) begin
            for (int k = 0; k < N; k++) begin
              res_d[bus.eng_waddr][k] = bus.eng_wdata[(N-k)*W-1 -: W];
            end
            count_d = count_inc;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.eng_done) begin
          if (count_inc != CW'(NW)) begin
            err_d = 1'b1;
          end
          state_d = DRAIN;
          row_d   = '0;
        end
      end

      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_a_d = mem_a[bus.eng_raddr_a];
    rdata_b_d = mem_b[bus.eng_raddr_b];
  end

  // De-skew: the buffer only changes in RUN, so this is stable in DRAIN.
  always_comb begin
    logic [SW-1:0] idx;
    out_data_c = '0;
    idx        = '0;
    for (int j = 0; j < N; j++) begin
      idx = SW'(row_q) + SW'(j);
      out_data_c[(N-j)*W-1 -: W] = res_q[idx][row_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      row_q     <= '0;
      count_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      for (int s = 0; s < NW; s++) begin
        for (int k = 0; k < N; k++) begin
          res_q[s][k] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      err_q     <= err_d;
      row_q     <= row_d;
      count_q   <= count_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      res_q     <= res_d;
    end
  end

  // Operand buffers are plain RAM: never cleared, written on accepted beats.
  always_ff @(posedge clock) begin
    if (!reset && load_fire) begin
      mem_a[bus.load_addr] <= bus.load_data_a;
      mem_b[bus.load_addr] <= bus.load_data_b;
    end
  end

endmodule

// File: tb/tb_mm_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mm_io_ctrl
//
// Directed bench for mm_io_ctrl with N=2, DATA_WIDTH=8, W=16, ADDR_WIDTH=4.
// A matrix-level model (operand arrays, result matrix C, phase, error flag)
// is advanced at every rising edge from the inputs present at that edge; a
// compare process checks the DUT against it on every falling edge. Literal
// expectations at key points pin the model.
// ---------------------------------------------------------------------------
module tb_mm_io_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int SW = $clog2(2 * N);
  localparam int NW = 2 * N - 1;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mm_io_ctrl_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .W(W), .ADDR_WIDTH(AW)) bus ();

  mm_io_ctrl #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .W(W), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [N*DW-1:0] m_mem_a [2**AW];
  logic [N*DW-1:0] m_mem_b [2**AW];
  bit              m_wr_a  [2**AW];
  bit              m_wr_b  [2**AW];
  logic [W-1:0]    m_c     [N][N];
  int              m_phase = P_IDLE;
  int              m_row   = 0;
  int              m_count = 0;
  bit              m_start = 1'b0;
  bit              m_err   = 1'b0;
  logic [N*DW-1:0] m_rda   = '0;
  logic [N*DW-1:0] m_rdb   = '0;
  bit              m_rda_ok = 1'b0;
  bit              m_rdb_ok = 1'b0;
  bit              chk_en  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N*W-1:0] expRow(input int r);
    logic [N*W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      v[(N-j)*W-1 -: W] = m_c[r][j];
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic modelStep();
    int s;
    if (reset) begin
      m_phase  = P_IDLE;
      m_row    = 0;
      m_start  = 1'b0;
      m_err    = 1'b0;
      m_rda    = '0;
      m_rdb    = '0;
      m_rda_ok = 1'b1;
      m_rdb_ok = 1'b1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          m_c[i][j] = '0;
    end else begin
      m_rda_ok = m_wr_a[bus.eng_raddr_a];
      m_rda    = m_mem_a[bus.eng_raddr_a];
      m_rdb_ok = m_wr_b[bus.eng_raddr_b];
      m_rdb    = m_mem_b[bus.eng_raddr_b];
      m_start  = 1'b0;
      case (m_phase)
        P_IDLE, P_LOAD: begin
          if (bus.input_valid) begin
            if (m_phase == P_IDLE) m_err = 1'b0;
            m_mem_a[bus.load_addr] = bus.load_data_a;
            m_mem_b[bus.load_addr] = bus.load_data_b;
            m_wr_a[bus.load_addr]  = 1'b1;
            m_wr_b[bus.load_addr]  = 1'b1;
            if (bus.load_last) begin
              m_phase = P_RUN;
              m_start = 1'b1;
              m_count = 0;
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  m_c[i][j] = '0;
            end else begin
              m_phase = P_LOAD;
            end
          end
        end
        P_RUN: begin
          if (bus.eng_wen) begin
            s = int'(bus.eng_waddr);
            if (s < NW) begin
              for (int k = 0; k < N; k++) begin
                if (s - k >= 0 && s - k < N) m_c[k][s-k] = bus.eng_wdata[(N-k)*W-1 -: W];
              end
              m_count++;
            end else begin
              m_err = 1'b1;
            end
          end
          if (bus.eng_done) begin
            if (m_count != NW) m_err = 1'b1;
            m_phase = P_DRAIN;
            m_row   = 0;
          end
        end
        default: begin
          if (bus.out_ready) begin
            if (m_row == N - 1) m_phase = P_IDLE;
            else m_row++;
          end
        end
      endcase
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      checkOutput("input_ready", 64'(bus.input_ready), 64'(m_phase == P_IDLE || m_phase == P_LOAD));
      checkOutput("busy", 64'(bus.busy), 64'(m_phase != P_IDLE));
      checkOutput("eng_start", 64'(bus.eng_start), 64'(m_start));
      checkOutput("err", 64'(bus.err), 64'(m_err));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(m_phase == P_DRAIN));
      if (m_phase == P_DRAIN) begin
        checkOutput("out_data", 64'(bus.out_data), 64'(expRow(m_row)));
        checkOutput("out_last", 64'(bus.out_last), 64'(m_row == N - 1));
      end else begin
        checkOutput("out_last_idle", 64'(bus.out_last), 64'(1'b0));
      end
      if (m_rda_ok) checkOutput("eng_rdata_a", 64'(bus.eng_rdata_a), 64'(m_rda));
      if (m_rdb_ok) checkOutput("eng_rdata_b", 64'(bus.eng_rdata_b), 64'(m_rdb));
    end
  end

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [AW-1:0] addr,
                               input logic [N*DW-1:0] da, input logic [N*DW-1:0] db,
                               input logic last, input logic wen,
                               input logic [SW-1:0] waddr, input logic [N*W-1:0] wdata,
                               input logic done, input logic ordy);
    bus.input_valid = iv;
    bus.load_addr   = addr;
    bus.load_data_a = da;
    bus.load_data_b = db;
    bus.load_last   = last;
    bus.eng_wen     = wen;
    bus.eng_waddr   = waddr;
    bus.eng_wdata   = wdata;
    bus.eng_done    = done;
    bus.out_ready   = ordy;
    tick();
  endtask

  task automatic idleCycle(input logic ordy);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic loadBeat(input logic [AW-1:0] addr, input logic [N*DW-1:0] da,
                          input logic [N*DW-1:0] db, input logic last);
    applyStimulus(1'b1, addr, da, db, last, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic engWrite(input logic [SW-1:0] s, input logic [N*W-1:0] data, input logic done);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, s, data, done, 1'b0);
  endtask

  task automatic engDone();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.eng_raddr_a = '0;
    bus.eng_raddr_b = '0;
    reset = 1'b1;
    idleCycle(1'b0);
    chk_en = 1'b1;
    idleCycle(1'b0);
    idleCycle(1'b0);
    @(negedge clock);
    checkOutput("rst_input_ready", 64'(bus.input_ready), 64'd1);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_eng_start", 64'(bus.eng_start), 64'd0);
    checkOutput("rst_err", 64'(bus.err), 64'd0);
    reset = 1'b0;

    // Load two rows, then read them back through the engine port.
    loadBeat(4'd0, 16'h0102, 16'h0506, 1'b0);
    loadBeat(4'd1, 16'h0304, 16'h0708, 1'b1);
    @(negedge clock);
    checkOutput("start_pulse", 64'(bus.eng_start), 64'd1);
    checkOutput("rdata_a_addr0", 64'(bus.eng_rdata_a), 64'h0102);
    checkOutput("run_input_ready", 64'(bus.input_ready), 64'd0);
    bus.eng_raddr_a = 4'd1;
    bus.eng_raddr_b = 4'd1;
    idleCycle(1'b0);
    @(negedge clock);
    checkOutput("start_single", 64'(bus.eng_start), 64'd0);
    checkOutput("rdata_a_addr1", 64'(bus.eng_rdata_a), 64'h0304);
    checkOutput("rdata_b_addr1", 64'(bus.eng_rdata_b), 64'h0708);

    // De-skew, with the last word arriving together with eng_done.
    engWrite(2'd0, 32'h0013_DEAD, 1'b0);
    engWrite(2'd1, 32'h0016_002B, 1'b0);
    engWrite(2'd2, 32'hBEEF_0032, 1'b1);
    @(negedge clock);
    checkOutput("row0_data", 64'(bus.out_data), 64'h0013_0016);
    checkOutput("row0_last", 64'(bus.out_last), 64'd0);
    checkOutput("deskew_err", 64'(bus.err), 64'd0);
    repeat (5) idleCycle(1'b0);
    @(negedge clock);
    checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("stall_data", 64'(bus.out_data), 64'h0013_0016);
    idleCycle(1'b1);
    @(negedge clock);
    checkOutput("row1_data", 64'(bus.out_data), 64'h002B_0032);
    checkOutput("row1_last", 64'(bus.out_last), 64'd1);
    idleCycle(1'b1);
    @(negedge clock);
    checkOutput("drain_end_valid", 64'(bus.out_valid), 64'd0);

    // Same-cycle write/read returns old data; incomplete result sets err.
    bus.eng_raddr_a = 4'd1;
    loadBeat(4'd1, 16'h0A0B, 16'h0C0D, 1'b0);
    @(negedge clock);
    checkOutput("rd_during_wr_old", 64'(bus.eng_rdata_a), 64'h0304);
    loadBeat(4'd2, 16'h1111, 16'h2222, 1'b1);
    @(negedge clock);
    checkOutput("rd_after_wr_new", 64'(bus.eng_rdata_a), 64'h0A0B);
    engWrite(2'd0, 32'h0011_1111, 1'b0);
    engWrite(2'd1, 32'h0022_0033, 1'b0);
    engDone();
    @(negedge clock);
    checkOutput("incomplete_err", 64'(bus.err), 64'd1);
    checkOutput("incomplete_row0", 64'(bus.out_data), 64'h0011_0022);
    idleCycle(1'b1);
    @(negedge clock);
    checkOutput("incomplete_row1", 64'(bus.out_data), 64'h0033_0000);
    idleCycle(1'b1);
    @(negedge clock);
    checkOutput("err_sticky_idle", 64'(bus.err), 64'd1);

    // err clears on the first beat; out-of-range index is dropped.
    loadBeat(4'd0, 16'h5555, 16'h6666, 1'b1);
    @(negedge clock);
    checkOutput("err_cleared", 64'(bus.err), 64'd0);
    engWrite(2'd0, 32'h0041_0000, 1'b0);
    engWrite(2'd1, 32'h0042_0043, 1'b0);
    engWrite(2'd3, 32'hFFFF_FFFF, 1'b0);
    @(negedge clock);
    checkOutput("range_err", 64'(bus.err), 64'd1);
    engWrite(2'd2, 32'h0000_0044, 1'b0);
    engDone();
    @(negedge clock);
    checkOutput("range_row0", 64'(bus.out_data), 64'h0041_0042);
    idleCycle(1'b1);
    @(negedge clock);
    checkOutput("range_row1", 64'(bus.out_data), 64'h0043_0044);

    // Reset in the middle of DRAIN abandons the stream.
    reset = 1'b1;
    idleCycle(1'b0);
    @(negedge clock);
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_err", 64'(bus.err), 64'd0);
    reset = 1'b0;
    idleCycle(1'b0);
    idleCycle(1'b0);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
